// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads sysid words 0/1 over Avalon-MM and reports
// whether the running build matches the expected ID and timestamp.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1418799084,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] tmo_cnt;
    logic        auto_pend;
    logic        accept;
    logic        go;
    logic        expired;
    logic        id_cap;
    logic        ts_cap;
    logic        id_hit;
    logic        ts_hit;

    assign accept  = avm_read & ~avm_waitrequest;
    assign go      = start | auto_pend;
    assign expired = (tmo_cnt + 16'd1) == TMO;
    assign id_hit  = avm_readdata == EXPECTED_ID;
    assign ts_hit  = avm_readdata == EXPECTED_TS;

    // Data returned in the accept cycle is taken without visiting WT.
    assign id_cap = avm_readdatavalid &
                    (((state == RD_ID) & accept) | (state == WT_ID));
    assign ts_cap = avm_readdatavalid &
                    (((state == RD_TS) & accept) | (state == WT_TS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            auto_pend   <= AUTO_START;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state       <= RD_ID;
                        auto_pend   <= 1'b0;
                        tmo_cnt     <= '0;
                        avm_address <= 1'b0;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                        id_value    <= '0;
                        ts_value    <= '0;
                    end
                end
                RD_ID, WT_ID: begin
                    if (id_cap) begin
                        id_value    <= avm_readdata;
                        tmo_cnt     <= '0;
                        avm_read    <= CHECK_TS;
                        avm_address <= CHECK_TS;
                        if (CHECK_TS) begin
                            state <= RD_TS;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            id_ok <= id_hit;
                            ts_ok <= 1'b1;
                        end
                    end else if (expired) begin
                        state       <= DONE;
                        avm_read    <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        id_ok       <= 1'b0;
                        ts_ok       <= ~CHECK_TS;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (accept) begin
                            avm_read <= 1'b0;
                            state    <= WT_ID;
                        end
                    end
                end
                RD_TS, WT_TS: begin
                    if (ts_cap) begin
                        ts_value <= avm_readdata;
                        avm_read <= 1'b0;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        id_ok    <= id_value == EXPECTED_ID;
                        ts_ok    <= ts_hit;
                    end else if (expired) begin
                        state       <= DONE;
                        avm_read    <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (accept) begin
                            avm_read <= 1'b0;
                            state    <= WT_TS;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: directed sequences against three configurations
// sharing one modelled sysid slave, with a result scoreboard.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_TS = 32'd1418799084;

    typedef struct {
        logic        iok;
        logic        tok;
        logic        tmo;
        logic [31:0] iv;
        logic [31:0] tv;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;

    logic a_addr, a_read, a_busy, a_done, a_iok, a_tok, a_tmo;
    logic b_addr, b_read, b_busy, b_done, b_iok, b_tok, b_tmo;
    logic c_addr, c_read, c_busy, c_done, c_iok, c_tok, c_tmo;
    logic [31:0] a_iv, a_tv, b_iv, b_tv, c_iv, c_tv;

    sysid_boot_checker u_a (
        .clock(clock), .reset(rst_a), .start(st_a),
        .avm_address(a_addr), .avm_read(a_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(a_busy), .done(a_done), .id_ok(a_iok), .ts_ok(a_tok),
        .timeout_err(a_tmo), .id_value(a_iv), .ts_value(a_tv)
    );

    sysid_boot_checker #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) u_b (
        .clock(clock), .reset(rst_b), .start(st_b),
        .avm_address(b_addr), .avm_read(b_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(b_busy), .done(b_done), .id_ok(b_iok), .ts_ok(b_tok),
        .timeout_err(b_tmo), .id_value(b_iv), .ts_value(b_tv)
    );

    sysid_boot_checker #(.CHECK_TS(1'b0), .AUTO_START(1'b0)) u_c (
        .clock(clock), .reset(rst_c), .start(st_c),
        .avm_address(c_addr), .avm_read(c_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(c_busy), .done(c_done), .id_ok(c_iok), .ts_ok(c_tok),
        .timeout_err(c_tmo), .id_value(c_iv), .ts_value(c_tv)
    );

    int sel = 0;
    logic cur_addr, cur_read, cur_busy, cur_done;
    logic cur_iok, cur_tok, cur_tmo;
    logic [31:0] cur_iv, cur_tv;

    always_comb begin
        cur_addr = a_addr; cur_read = a_read; cur_busy = a_busy;
        cur_done = a_done; cur_iok = a_iok; cur_tok = a_tok;
        cur_tmo = a_tmo; cur_iv = a_iv; cur_tv = a_tv;
        case (sel)
            1: begin
                cur_addr = b_addr; cur_read = b_read; cur_busy = b_busy;
                cur_done = b_done; cur_iok = b_iok; cur_tok = b_tok;
                cur_tmo = b_tmo; cur_iv = b_iv; cur_tv = b_tv;
            end
            2: begin
                cur_addr = c_addr; cur_read = c_read; cur_busy = c_busy;
                cur_done = c_done; cur_iok = c_iok; cur_tok = c_tok;
                cur_tmo = c_tmo; cur_iv = c_iv; cur_tv = c_tv;
            end
            default: ;
        endcase
    end

    int checks = 0;
    int failures = 0;
    exp_t sbq[$];
    logic addrq[$];

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Slave model: configurable stall and read latency, driven at negedge.
    int stall_cfg = 0, lat_cfg = 0, stall_left = 0, pend = 0;
    int accepts = 0;
    logic [31:0] w0 = '0, w1 = EXP_TS, inj_data = '0;
    bit drop_ts = 1'b0, inj = 1'b0, in_stall = 1'b0;
    logic pend_addr = 1'b0, hold_addr = 1'b0;

    always @(negedge clock) begin
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = pend_addr ? w1 : w0;
            end
        end
        if (inj) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = inj_data;
            inj = 1'b0;
        end
        if (in_stall) begin
            chk1("stall_read", cur_read, 1'b1);
            chk1("stall_addr", cur_addr, hold_addr);
            in_stall = 1'b0;
        end
        if (cur_read === 1'b1) begin
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
                in_stall = 1'b1;
                hold_addr = cur_addr;
            end else begin
                stall_left = stall_cfg;
                accepts++;
                chk1("rd_expected", addrq.size() > 0, 1'b1);
                if (addrq.size() > 0)
                    chk1("rd_addr", cur_addr, addrq.pop_front());
                if (!(cur_addr && drop_ts)) begin
                    if (lat_cfg == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = cur_addr ? w1 : w0;
                    end else begin
                        pend = lat_cfg;
                        pend_addr = cur_addr;
                    end
                end
            end
        end
    end

    task automatic slave_cfg(int st, int lat);
        stall_cfg = st;
        stall_left = st;
        lat_cfg = lat;
    endtask

    task automatic expect_res(logic iok, logic tok, logic tmo,
                              logic [31:0] iv, logic [31:0] tv);
        exp_t e;
        e.iok = iok; e.tok = tok; e.tmo = tmo; e.iv = iv; e.tv = tv;
        sbq.push_back(e);
    endtask

    task automatic pulse_start(int which);
        @(negedge clock);
        case (which)
            0: st_a = 1'b1;
            1: st_b = 1'b1;
            default: st_c = 1'b1;
        endcase
        @(negedge clock);
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
    endtask

    task automatic wait_done(string tag, int maxc);
        int n = 0;
        while (cur_done !== 1'b1 && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk1(tag, cur_done, 1'b1);
    endtask

    task automatic wait_ts_issue(string tag, int maxc);
        int n = 0;
        while (!(cur_read === 1'b1 && cur_addr === 1'b1) && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk1(tag, cur_read & cur_addr, 1'b1);
    endtask

    task automatic check_sb(string tag);
        exp_t e;
        chk1({tag, "_sb"}, sbq.size() > 0, 1'b1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk1({tag, "_busy"}, cur_busy, 1'b0);
            chk1({tag, "_id_ok"}, cur_iok, e.iok);
            chk1({tag, "_ts_ok"}, cur_tok, e.tok);
            chk1({tag, "_tmo"}, cur_tmo, e.tmo);
            chk32({tag, "_id_val"}, cur_iv, e.iv);
            chk32({tag, "_ts_val"}, cur_tv, e.tv);
        end
    endtask

    initial begin
        int mark;
        int n;
        slave_cfg(0, 0);
        repeat (2) @(negedge clock);
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_done", a_done, 1'b0);
        chk1("rst_read", a_read, 1'b0);
        chk32("rst_id_val", a_iv, 32'd0);

        // Auto-start on reset release with a zero-wait slave
        addrq.push_back(1'b0);
        addrq.push_back(1'b1);
        expect_res(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        mark = accepts;
        @(negedge clock);
        rst_a = 1'b0;
        @(negedge clock);
        chk1("t1_c1_busy", cur_busy, 1'b1);
        chk1("t1_c1_addr", cur_addr, 1'b0);
        @(negedge clock);
        chk1("t1_c2_addr", cur_addr, 1'b1);
        chk1("t1_c2_done", cur_done, 1'b0);
        @(negedge clock);
        chk1("t1_c3_done", cur_done, 1'b1);
        check_sb("t1");
        chk32("t1_reads", 32'(accepts - mark), 32'd2);

        // Stalled slave with two-cycle read latency
        slave_cfg(4, 2);
        addrq.push_back(1'b0);
        addrq.push_back(1'b1);
        expect_res(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        mark = accepts;
        pulse_start(0);
        chk1("t2_done_clr", cur_done, 1'b0);
        wait_done("t2_done", 60);
        check_sb("t2");
        chk32("t2_reads", 32'(accepts - mark), 32'd2);

        // Timestamp off by one
        slave_cfg(0, 0);
        w1 = EXP_TS + 32'd1;
        addrq.push_back(1'b0);
        addrq.push_back(1'b1);
        expect_res(1'b1, 1'b0, 1'b0, 32'd0, EXP_TS + 32'd1);
        pulse_start(0);
        wait_done("t3_done", 20);
        check_sb("t3");

        // CHECK_TS=0 instance: idle stray data, then single read
        sel = 2;
        @(negedge clock);
        rst_c = 1'b0;
        repeat (3) @(negedge clock);
        chk1("c_idle_busy", cur_busy, 1'b0);
        chk1("c_idle_read", cur_read, 1'b0);
        mark = accepts;
        inj_data = 32'hDEAD_BEEF;
        inj = 1'b1;
        repeat (2) @(negedge clock);
        chk32("c_idle_id_val", cur_iv, 32'd0);
        chk1("c_idle_done", cur_done, 1'b0);
        addrq.push_back(1'b0);
        expect_res(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        pulse_start(2);
        wait_done("t3c_done", 20);
        check_sb("t3c");
        chk32("t3c_reads", 32'(accepts - mark), 32'd1);
        w1 = EXP_TS;

        // Timeout on word 1, TIMEOUT_CYCLES=8
        sel = 1;
        @(negedge clock);
        rst_b = 1'b0;
        repeat (3) @(negedge clock);
        chk1("b_idle_read", cur_read, 1'b0);
        drop_ts = 1'b1;
        addrq.push_back(1'b0);
        addrq.push_back(1'b1);
        expect_res(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        pulse_start(1);
        wait_ts_issue("t4_ts_issue", 10);
        n = 0;
        while (cur_done !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk32("t4_tmo_cycles", 32'(n), 32'd8);
        check_sb("t4");
        drop_ts = 1'b0;

        // Reset during WT_TS aborts the sequence
        slave_cfg(0, 3);
        addrq.push_back(1'b0);
        addrq.push_back(1'b1);
        pulse_start(1);
        wait_ts_issue("t5_ts_issue", 20);
        @(negedge clock);
        chk1("t5_wt_busy", cur_busy, 1'b1);
        chk1("t5_wt_read", cur_read, 1'b0);
        rst_b = 1'b1;
        #1;
        chk1("t5_rst_busy", cur_busy, 1'b0);
        chk1("t5_rst_addr", cur_addr, 1'b0);
        chk1("t5_rst_done", cur_done, 1'b0);
        chk1("t5_rst_tmo", cur_tmo, 1'b0);
        repeat (4) @(negedge clock);
        rst_b = 1'b0;
        mark = accepts;
        repeat (5) @(negedge clock);
        chk32("t5_no_reads", 32'(accepts - mark), 32'd0);
        chk1("t5_idle_done", cur_done, 1'b0);
        chk32("t5_idle_id", cur_iv, 32'd0);
        slave_cfg(0, 0);
        addrq.push_back(1'b0);
        addrq.push_back(1'b1);
        expect_res(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        pulse_start(1);
        wait_done("t5_done", 20);
        check_sb("t5");

        // Stray data in DONE and start pulses while busy
        inj_data = 32'h1234_5678;
        inj = 1'b1;
        repeat (2) @(negedge clock);
        chk32("t6_done_ts", cur_tv, EXP_TS);
        chk32("t6_done_id", cur_iv, 32'd0);
        chk1("t6_done_ok", cur_tok, 1'b1);
        slave_cfg(3, 1);
        addrq.push_back(1'b0);
        addrq.push_back(1'b1);
        expect_res(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        mark = accepts;
        pulse_start(1);
        chk1("t6_busy", cur_busy, 1'b1);
        pulse_start(1);
        pulse_start(1);
        wait_done("t6_done", 40);
        check_sb("t6");
        repeat (6) @(negedge clock);
        chk32("t6_reads", 32'(accepts - mark), 32'd2);
        chk1("t6_hold_done", cur_done, 1'b1);
        chk32("t6_addrq_empty", 32'(addrq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
